// File: rtl/niosii_tutorial_cpu_oci_monitor_mem.sv
// OCI debug-monitor memory engine: turns JTAG ocimem commands into single-word req/ack transactions.
// Optional OCIMEM_AUTOINC_EN: post-increment MonAReg after every acknowledged transaction.
module niosii_tutorial_cpu_oci_monitor_mem #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t              r_state;
  logic [15:0]         r_tcnt;
  logic                r_mem_req;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mon_a;
  logic [31:0]         r_mon_d;
  logic                r_ready;
  logic                r_error;

  logic w_any_strobe;
  logic w_unused;

  assign w_any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_unused     = ^{jdo[37:36], jdo[2:0]};

  // Address and write data come straight from the monitor registers; both are
  // frozen while BUSY, so the memory port sees stable values for the whole request.
  assign mem_req       = r_mem_req;
  assign mem_wr        = r_mem_wr;
  assign mem_addr      = r_mon_a;
  assign mem_wdata     = r_mon_d;
  assign MonAReg       = r_mon_a;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_tcnt    <= '0;
      r_mem_req <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mon_a   <= '0;
      r_mon_d   <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (take_action_ocimem_b) begin
            r_mon_d   <= jdo[34:3];
            r_mem_wr  <= 1'b1;
            r_mem_req <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= ST_BUSY;
          end else if (take_action_ocimem_a) begin
            if (jdo[35]) r_error <= 1'b0;
            if (jdo[17]) r_mon_a <= jdo[18 +: ADDR_W];
            if (jdo[34]) begin
              r_mem_wr  <= 1'b0;
              r_mem_req <= 1'b1;
              r_ready   <= 1'b0;
              r_state   <= ST_BUSY;
            end else begin
              r_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            r_mem_wr  <= 1'b0;
            r_mem_req <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Commands arriving mid-transaction are dropped but flagged.
          if (w_any_strobe) r_error <= 1'b1;
          if (mem_ack) begin
            if (!r_mem_wr) r_mon_d <= mem_rdata;
`ifdef OCIMEM_AUTOINC_EN
            r_mon_a <= r_mon_a + ONE_A;
`endif
            r_mem_req <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_tcnt == TO_LAST) begin
            r_mem_req <= 1'b0;
            r_error   <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_niosii_tutorial_cpu_oci_monitor_mem.sv
// Scoreboard bench for the OCI monitor memory engine; a memory responder pops expected
// transactions when mem_req rises. Define OCIMEM_AUTOINC_EN to match an autoinc build.
module tb_niosii_tutorial_cpu_oci_monitor_mem;

`ifdef OCIMEM_AUTOINC_EN
  localparam logic [7:0] AUTO = 8'd1;
`else
  localparam logic [7:0] AUTO = 8'd0;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        mem_req, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int n_checks = 0;
  int n_errs = 0;

  txn_t        exp_q[$];
  txn_t        rsp_t;
  logic        in_txn = 1'b0;
  logic [7:0]  cur_addr = '0;
  int          rsp_cnt = 0;
  int          ack_dly = 2;
  logic        ack_en = 1'b1;
  logic [31:0] rsp_data = '0;

  logic [7:0]  exp_a;
  logic [31:0] d0;
  logic [37:0] d;
  int          req_cycles;

  niosii_tutorial_cpu_oci_monitor_mem #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MonAReg(MonAReg), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory responder: first cycle of a request is compared against the scoreboard.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!in_txn) begin
        in_txn  = 1'b1;
        rsp_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_req", mem_req, 1'b0);
        end else begin
          rsp_t    = exp_q.pop_front();
          cur_addr = rsp_t.addr;
          check("mem_wr", mem_wr, rsp_t.wr);
          check("mem_addr", mem_addr, rsp_t.addr);
          if (rsp_t.wr) check("mem_wdata", mem_wdata, rsp_t.wdata);
          $display("txn wr=%0b addr=%02h wdata=%08h", mem_wr, mem_addr, mem_wdata);
        end
      end else begin
        check("addr_stable", mem_addr, cur_addr);
      end
      if (ack_en && rsp_cnt == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rsp_data;
      end
      rsp_cnt++;
    end else begin
      in_txn = 1'b0;
    end
  end

  task automatic strobe(input logic sa, input logic sb, input logic sn, input logic [37:0] dv);
    @(negedge clk);
    jdo = dv;
    take_action_ocimem_a = sa;
    take_action_ocimem_b = sb;
    take_no_action_ocimem_a = sn;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input int max);
    int i = 0;
    while (!(monitor_ready && !mem_req) && i < max) begin
      @(negedge clk);
      i++;
    end
    if (!(monitor_ready && !mem_req)) check("ready_wait", monitor_ready, 1'b1);
  endtask

  function automatic logic [37:0] cmd_a(input logic clr, input logic rd, input logic ld,
                                        input logic [7:0] addr);
    logic [37:0] v = '0;
    v[35] = clr;
    v[34] = rd;
    v[17] = ld;
    v[25:18] = addr;
    return v;
  endfunction

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_mond", MonDReg, 32'h0);
    check("rst_mona", MonAReg, 8'h0);
    check("rst_ready", monitor_ready, 1'b0);
    check("rst_error", monitor_error, 1'b0);
    reset_n = 1'b1;
    exp_a = 8'h00;

    // Load-and-read at 0x10
    exp_q.push_back('{1'b0, 8'h10, 32'h0});
    rsp_data = 32'hCAFEF00D;
    ack_dly = 2;
    strobe(1'b1, 1'b0, 1'b0, cmd_a(1'b0, 1'b1, 1'b1, 8'h10));
    wait_ready(50);
    exp_a = 8'h10 + AUTO;
    check("rd_mond", MonDReg, 32'hCAFEF00D);
    check("rd_ready", monitor_ready, 1'b1);
    check("rd_mona", MonAReg, exp_a);

    // Write 0x12345678
    d = '0; d[34:3] = 32'h12345678;
    exp_q.push_back('{1'b1, exp_a, 32'h12345678});
    ack_dly = 0;
    strobe(1'b0, 1'b1, 1'b0, d);
    wait_ready(50);
    exp_a = exp_a + AUTO;
    check("wr_mond", MonDReg, 32'h12345678);
    check("wr_ready", monitor_ready, 1'b1);
    check("wr_mona", MonAReg, exp_a);

    // Priority: write beats read-next in the same cycle
    d = '0; d[34:3] = 32'hA5A55A5A;
    exp_q.push_back('{1'b1, exp_a, 32'hA5A55A5A});
    ack_dly = 1;
    strobe(1'b0, 1'b1, 1'b1, d);
    wait_ready(50);
    exp_a = exp_a + AUTO;
    check("prio_mond", MonDReg, 32'hA5A55A5A);
    check("prio_err", monitor_error, 1'b0);

    // Load 0xFF without read, then two read-next commands
    strobe(1'b1, 1'b0, 1'b0, cmd_a(1'b0, 1'b0, 1'b1, 8'hFF));
    check("ld_ready", monitor_ready, 1'b1);
    check("ld_mona", MonAReg, 8'hFF);
    check("ld_req", mem_req, 1'b0);
    exp_a = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b0, exp_a, 32'h0});
      rsp_data = 32'h11110000 + 32'(k);
      strobe(1'b0, 1'b0, 1'b1, '0);
      wait_ready(50);
      exp_a = exp_a + AUTO;
      check("nx_mond", MonDReg, 32'h11110000 + 32'(k));
      check("nx_mona", MonAReg, exp_a);
    end

    // Timeout: responder never acks
    ack_en = 1'b0;
    d0 = MonDReg;
    exp_q.push_back('{1'b0, exp_a, 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    req_cycles = 0;
    for (int i = 0; i < 400 && mem_req; i++) begin
      req_cycles++;
      @(negedge clk);
    end
    check("to_cycles", 64'(req_cycles), 64'd255);
    check("to_error", monitor_error, 1'b1);
    check("to_ready", monitor_ready, 1'b1);
    check("to_mond", MonDReg, d0);
    check("to_mona", MonAReg, exp_a);
    ack_en = 1'b1;
    strobe(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 1'b0, 8'h00));
    check("clr_error", monitor_error, 1'b0);
    check("clr_ready", monitor_ready, 1'b1);

    // Strobe while busy is dropped and flagged
    ack_dly = 6;
    rsp_data = 32'h0BADBEEF;
    exp_q.push_back('{1'b0, exp_a, 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    strobe(1'b0, 1'b0, 1'b1, '0);
    wait_ready(50);
    exp_a = exp_a + AUTO;
    check("busy_error", monitor_error, 1'b1);
    check("busy_mond", MonDReg, 32'h0BADBEEF);
    repeat (5) begin
      @(negedge clk);
      check("busy_noreq", mem_req, 1'b0);
    end
    strobe(1'b1, 1'b0, 1'b0, cmd_a(1'b1, 1'b0, 1'b0, 8'h00));
    check("busy_clr", monitor_error, 1'b0);

    // Reset during a transaction
    ack_en = 1'b0;
    exp_q.push_back('{1'b0, exp_a, 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    repeat (3) @(negedge clk);
    check("pre_rst_req", mem_req, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_mona", MonAReg, 8'h00);
    check("mid_rst_ready", monitor_ready, 1'b0);
    reset_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_req", mem_req, 1'b0);
    end

    check("sb_left", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
